// File: rtl/router_pkg.sv
// Shared types and helpers for the router packet source.
// Latency: none (declarations only).
// Backpressure: n/a.
package router_pkg;

  localparam int ADDR_W    = 2;
  localparam int LEN_W     = 6;
  localparam int NUM_PORTS = 3;
  // Port numbers run 0..NUM_PORTS-1, so the first code past them is illegal.
  localparam logic [ADDR_W-1:0] ADDR_ILLEGAL = ADDR_W'(NUM_PORTS);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HEADER,
    PAYLOAD,
    PARITY,
    CHECK
  } tx_state_e;

  // Router framing header: length in the upper bits, destination in the low bits.
  function automatic logic [7:0] pack_hdr(input logic [ADDR_W-1:0] addr,
                                          input logic [LEN_W-1:0]  len);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// Request, payload and router-side signals of the packet source.
// Latency: none (wiring only).
// Backpressure: req/pay use valid-ready; router side uses busy.
interface router_pkt_tx_if;
  logic                       req_valid;
  logic                       req_ready;
  logic [router_pkg::ADDR_W-1:0] req_addr;
  logic [router_pkg::LEN_W-1:0]  req_len;
  logic                       pay_valid;
  logic                       pay_ready;
  logic [7:0]                 pay_data;
  logic                       busy;
  logic                       err;
  logic                       pkt_valid;
  logic [7:0]                 data_out;
  logic                       done;
  logic                       done_err;
  logic                       done_bad;

  // Side that issues requests/payload and models the router.
  modport master (
    output req_valid, req_addr, req_len, pay_valid, pay_data, busy, err,
    input  req_ready, pay_ready, pkt_valid, data_out, done, done_err, done_bad
  );

  // The packet source itself.
  modport slave (
    input  req_valid, req_addr, req_len, pay_valid, pay_data, busy, err,
    output req_ready, pay_ready, pkt_valid, data_out, done, done_err, done_bad
  );
endinterface

// File: rtl/router_tx_buf.sv
// Byte buffer holding one packet payload: synchronous write, combinational read.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the caller owns pointer sequencing.
module router_tx_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o
);

  logic [7:0] mem_q [DEPTH];

  // Store one payload byte per write strobe; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/router_pkt_tx.sv
// Router input-port packet source: buffers a payload, then sends header/payload/parity.
// Latency: header appears the cycle after the last payload handshake (accept edge if len==0).
// Backpressure: busy freezes data_out/pkt_valid; req/pay ready only in IDLE/LOAD.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int ERR_WAIT = 3,
  parameter int MAX_LEN  = 63
) (
  input  logic           clk,
  input  logic           resetn,
  router_pkt_tx_if.slave tx
);

  tx_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [7:0]        par_q, par_d;
  logic [7:0]        data_q, data_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              err_flag_q, err_flag_d;
  logic              pkt_valid_q, pkt_valid_d;
  logic              done_q, done_d;
  logic              done_err_q, done_err_d;
  logic              done_bad_q, done_bad_d;
  logic              wr_en;
  logic [7:0]        rd_data;
  logic [7:0]        hdr_new;
  logic [7:0]        hdr_cur;

  assign hdr_new = pack_hdr(tx.req_addr, tx.req_len);
  assign hdr_cur = pack_hdr(addr_q, len_q);

  router_tx_buf #(
    .DEPTH (MAX_LEN + 1),
    .AW    (LEN_W)
  ) u_buf (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (tx.pay_data),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  assign tx.req_ready = (state_q == IDLE);
  assign tx.pay_ready = (state_q == LOAD);
  assign tx.pkt_valid = pkt_valid_q;
  assign tx.data_out  = data_q;
  assign tx.done      = done_q;
  assign tx.done_err  = done_err_q;
  assign tx.done_bad  = done_bad_q;

  // Next-state and registered-output logic; a byte only advances when busy is low.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    par_d       = par_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    err_flag_d  = err_flag_q;
    pkt_valid_d = pkt_valid_q;
    done_d      = 1'b0;
    done_err_d  = 1'b0;
    done_bad_d  = 1'b0;
    wr_en       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (tx.req_valid) begin
          if (tx.req_addr == ADDR_ILLEGAL) begin
            done_d     = 1'b1;
            done_bad_d = 1'b1;
          end else begin
            addr_d   = tx.req_addr;
            len_d    = tx.req_len;
            par_d    = hdr_new;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            if (tx.req_len == '0) begin
              state_d     = HEADER;
              data_d      = hdr_new;
              pkt_valid_d = 1'b1;
            end else begin
              state_d = LOAD;
            end
          end
        end
      end
      LOAD: begin
        if (tx.pay_valid) begin
          wr_en    = 1'b1;
          par_d    = par_q ^ tx.pay_data;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (wr_ptr_q == len_q - 1'b1) begin
            state_d     = HEADER;
            data_d      = hdr_cur;
            pkt_valid_d = 1'b1;
          end
        end
      end
      HEADER: begin
        if (!tx.busy) begin
          if (len_q != '0) begin
            state_d  = PAYLOAD;
            data_d   = rd_data;
            rd_ptr_d = rd_ptr_q + 1'b1;
          end else begin
            state_d     = PARITY;
            data_d      = par_q;
            pkt_valid_d = 1'b0;
          end
        end
      end
      PAYLOAD: begin
        if (!tx.busy) begin
          if (rd_ptr_q != len_q) begin
            data_d   = rd_data;
            rd_ptr_d = rd_ptr_q + 1'b1;
          end else begin
            state_d     = PARITY;
            data_d      = par_q;
            pkt_valid_d = 1'b0;
          end
        end
      end
      PARITY: begin
        if (!tx.busy) begin
          state_d    = CHECK;
          cnt_d      = 3'(ERR_WAIT);
          err_flag_d = 1'b0;
          data_d     = '0;
        end
      end
      CHECK: begin
        err_flag_d = err_flag_q | tx.err;
        cnt_d      = cnt_q - 1'b1;
        if (cnt_q == 3'd1) begin
          done_d     = 1'b1;
          done_err_d = err_flag_q | tx.err;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; synchronous reset aborts any packet in flight.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      par_q       <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      err_flag_q  <= 1'b0;
      pkt_valid_q <= 1'b0;
      done_q      <= 1'b0;
      done_err_q  <= 1'b0;
      done_bad_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      par_q       <= par_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      err_flag_q  <= err_flag_d;
      pkt_valid_q <= pkt_valid_d;
      done_q      <= done_d;
      done_err_q  <= done_err_d;
      done_bad_q  <= done_bad_d;
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: queue-based packet model plus directed literals.
// Latency: checks every cycle on the falling edge.
// Backpressure: exercises busy stalls, payload gaps and back-to-back requests.
module tb_router_pkt_tx;

  localparam int ERR_WAIT = 3;

  logic clk;
  logic resetn;
  router_pkt_tx_if bus();

  router_pkt_tx #(
    .ERR_WAIT (ERR_WAIT),
    .MAX_LEN  (63)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .tx     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  // ---------------- behavioural model ----------------
  // Expected router-side bytes as {pkt_valid, data}; empty queue means quiet bus (0,0).
  logic [8:0] m_out_q[$];
  logic [7:0] m_pay[$];
  logic [7:0] m_hdr;
  bit         m_idle = 1'b1;
  int         m_load_left = 0;
  int         m_chk = 0;
  bit         m_err = 1'b0;
  bit         exp_done = 1'b0;
  bit         exp_derr = 1'b0;
  bit         exp_dbad = 1'b0;

  function automatic void build_frame();
    logic [7:0] p;
    p = m_hdr;
    m_out_q.push_back({1'b1, m_hdr});
    foreach (m_pay[i]) begin
      m_out_q.push_back({1'b1, m_pay[i]});
      p = p ^ m_pay[i];
    end
    m_out_q.push_back({1'b0, p});
  endfunction

  // Compare current outputs, then advance the model with the inputs for the coming edge.
  always @(negedge clk) begin
    logic [8:0] cur;
    cur = (m_out_q.size() > 0) ? m_out_q[0] : 9'h000;
    if (chk_en) begin
      check("m.pkt_valid", 32'(bus.pkt_valid), 32'(cur[8]));
      check("m.data_out",  32'(bus.data_out),  32'(cur[7:0]));
      check("m.req_ready", 32'(bus.req_ready), 32'(m_idle));
      check("m.pay_ready", 32'(bus.pay_ready), 32'(m_load_left > 0));
      check("m.done",      32'(bus.done),      32'(exp_done));
      check("m.done_err",  32'(bus.done_err),  32'(exp_derr));
      check("m.done_bad",  32'(bus.done_bad),  32'(exp_dbad));
    end
    if (!resetn) begin
      m_idle = 1'b1; m_load_left = 0; m_chk = 0; m_out_q.delete();
      exp_done = 1'b0; exp_derr = 1'b0; exp_dbad = 1'b0;
    end else begin
      exp_done = 1'b0; exp_derr = 1'b0; exp_dbad = 1'b0;
      if (m_idle) begin
        if (bus.req_valid) begin
          if (bus.req_addr == 2'd3) begin
            exp_done = 1'b1; exp_dbad = 1'b1;
          end else begin
            m_hdr = {bus.req_len, bus.req_addr};
            m_pay.delete();
            m_idle = 1'b0;
            m_load_left = int'(bus.req_len);
            if (m_load_left == 0) build_frame();
          end
        end
      end else if (m_load_left > 0) begin
        if (bus.pay_valid) begin
          m_pay.push_back(bus.pay_data);
          m_load_left--;
          if (m_load_left == 0) build_frame();
        end
      end else if (m_out_q.size() > 0) begin
        if (!bus.busy) begin
          void'(m_out_q.pop_front());
          if (m_out_q.size() == 0) begin
            m_chk = ERR_WAIT; m_err = 1'b0;
          end
        end
      end else if (m_chk > 0) begin
        m_err = m_err | bus.err;
        m_chk--;
        if (m_chk == 0) begin
          exp_done = 1'b1; exp_derr = m_err; m_idle = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [1:0] a, input logic [5:0] l);
    bus.req_valid = 1'b1; bus.req_addr = a; bus.req_len = l;
    tick();
    bus.req_valid = 1'b0; bus.req_addr = 2'(3); bus.req_len = 6'h3f;
  endtask

  task automatic payload(input logic [7:0] b[$]);
    foreach (b[i]) begin
      bus.pay_valid = 1'b1; bus.pay_data = b[i];
      tick();
    end
    bus.pay_valid = 1'b0; bus.pay_data = 8'hEE;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check(nm, 32'(bus.done), 32'd1);
  endtask

  task automatic chk_byte(input string nm, input logic pv, input logic [7:0] d);
    check(nm, 32'({bus.pkt_valid, bus.data_out}), 32'({pv, d}));
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic [7:0] pl[$];
    resetn = 1'b0;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_len = '0;
    bus.pay_valid = 1'b0; bus.pay_data = '0; bus.busy = 1'b0; bus.err = 1'b0;
    tick(); tick();
    chk_byte("rst out", 1'b0, 8'h00);
    check("rst done", 32'({bus.done, bus.done_err, bus.done_bad}), 32'd0);
    check("rst req_ready", 32'(bus.req_ready), 32'd1);
    check("rst pay_ready", 32'(bus.pay_ready), 32'd0);
    chk_en = 1'b1;
    resetn = 1'b1;
    tick();

    // addr=1 len=3, err pulses outside CHECK must be ignored
    pl = {8'h11, 8'h22, 8'h33};
    request(2'd1, 6'd3);
    bus.err = 1'b1;
    payload(pl);
    chk_byte("t1 hdr", 1'b1, 8'h0D); tick();
    chk_byte("t1 b0", 1'b1, 8'h11);  tick();
    chk_byte("t1 b1", 1'b1, 8'h22);  tick();
    chk_byte("t1 b2", 1'b1, 8'h33);  bus.err = 1'b0; tick();
    chk_byte("t1 par", 1'b0, 8'h0D); tick();
    chk_byte("t1 quiet", 1'b0, 8'h00); tick(); tick();
    check("t1 no early done", 32'(bus.done), 32'd0); tick();
    check("t1 done", 32'({bus.done, bus.done_err, bus.done_bad}), 32'b100);
    tick();

    // same packet, busy high two cycles on 0x22
    request(2'd1, 6'd3);
    payload(pl);
    chk_byte("t2 hdr", 1'b1, 8'h0D); tick();
    chk_byte("t2 b0", 1'b1, 8'h11);  tick();
    chk_byte("t2 b1", 1'b1, 8'h22);  bus.busy = 1'b1; tick();
    chk_byte("t2 hold1", 1'b1, 8'h22); tick();
    chk_byte("t2 hold2", 1'b1, 8'h22); bus.busy = 1'b0; tick();
    chk_byte("t2 b2", 1'b1, 8'h33);  tick();
    chk_byte("t2 par", 1'b0, 8'h0D);
    wait_done("t2 done");
    check("t2 done_err", 32'(bus.done_err), 32'd0);
    tick();

    // addr=2 len=0: header then parity, no payload phase
    request(2'd2, 6'd0);
    chk_byte("t3 hdr", 1'b1, 8'h02);
    check("t3 pay_ready", 32'(bus.pay_ready), 32'd0); tick();
    chk_byte("t3 par", 1'b0, 8'h02);
    wait_done("t3 done");
    check("t3 flags", 32'({bus.done_err, bus.done_bad}), 32'd0);
    tick();

    // illegal address
    bus.pay_valid = 1'b1;
    request(2'd3, 6'd5);
    check("t4 done", 32'({bus.done, bus.done_err, bus.done_bad}), 32'b101);
    check("t4 pay_ready", 32'(bus.pay_ready), 32'd0);
    chk_byte("t4 out", 1'b0, 8'h00);
    bus.pay_valid = 1'b0;
    tick();
    check("t4 done clr", 32'(bus.done), 32'd0);

    // addr=0 len=2 with err in CHECK, then back-to-back request
    pl = {8'h5A, 8'hC3};
    request(2'd0, 6'd2);
    bus.pay_valid = 1'b1; bus.pay_data = 8'h5A; tick();
    bus.pay_valid = 1'b0; tick();            // upstream gap
    bus.pay_valid = 1'b1; bus.pay_data = 8'hC3; tick();
    bus.pay_valid = 1'b0;
    chk_byte("t5 hdr", 1'b1, 8'h08); tick(); tick(); tick();
    chk_byte("t5 par", 1'b0, 8'h91); tick();
    bus.err = 1'b1; tick(); bus.err = 1'b0;
    wait_done("t5 done");
    check("t5 done_err", 32'(bus.done_err), 32'd1);
    check("t5 req_ready", 32'(bus.req_ready), 32'd1);
    request(2'd1, 6'd1);
    check("t5 accepted", 32'(bus.pay_ready), 32'd1);
    pl = {8'hA5};
    payload(pl);
    chk_byte("t5b hdr", 1'b1, 8'h05); tick();
    chk_byte("t5b b0", 1'b1, 8'hA5);  tick();
    chk_byte("t5b par", 1'b0, 8'hA0);
    wait_done("t5b done");
    check("t5b done_err", 32'(bus.done_err), 32'd0);
    tick();

    // reset during payload byte 2 of a len=10 packet
    pl.delete();
    for (int i = 0; i < 10; i++) pl.push_back(8'(8'h40 + i));
    request(2'd0, 6'd10);
    payload(pl);
    chk_byte("t6 hdr", 1'b1, 8'h28); tick(); tick(); tick();
    chk_byte("t6 b2", 1'b1, 8'h42);
    resetn = 1'b0; tick();
    chk_byte("t6 abort", 1'b0, 8'h00);
    check("t6 req_ready", 32'(bus.req_ready), 32'd1);
    check("t6 no done", 32'(bus.done), 32'd0);
    resetn = 1'b1; tick(); tick();
    check("t6 still no done", 32'(bus.done), 32'd0);
    pl = {8'h11, 8'h22, 8'h33};
    request(2'd1, 6'd3);
    payload(pl);
    chk_byte("t6 new hdr", 1'b1, 8'h0D);
    bus.busy = 1'b1; tick();
    chk_byte("t6 hdr held", 1'b1, 8'h0D);
    bus.busy = 1'b0; tick();
    chk_byte("t6 new b0", 1'b1, 8'h11);
    wait_done("t6 new done");
    check("t6 new done_err", 32'(bus.done_err), 32'd0);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, summary not reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
Packet source for the 1x3 router input port; it drives the router's pkt_valid/data_in pair.
Accepts a request (destination address, payload length), buffers the whole payload from an upstream byte stream, then emits header, payload and parity bytes in router framing.
Obeys the router's busy back-pressure.
Samples the router's err after the parity byte and reports a per-packet completion status.

Parameters:
- ERR_WAIT, 3, number of cycles err is observed after the parity byte is consumed (1..7).
- MAX_LEN, 63, maximum payload length; fixed by the 6-bit length field.

Ports:
- clk  input  1  clock.
- resetn  input  1  reset, synchronous, active-low.
- req_valid  input  1  packet request valid.
- req_ready  output  1  request accepted when req_valid & req_ready at a clock edge.
- req_addr  input  2  destination port 0..2; 3 is illegal.
- req_len  input  6  payload byte count 0..63.
- pay_valid  input  1  upstream payload byte valid.
- pay_ready  output  1  payload byte accepted when pay_valid & pay_ready at an edge.
- pay_data  input  8  payload byte.
- busy  input  1  router back-pressure; the current byte is not consumed while high.
- err  input  1  router parity-error flag.
- pkt_valid  output  1  high for header and payload bytes, low for the parity byte.
- data_out  output  8  byte to router data_in.
- done  output  1  one-cycle completion pulse.
- done_err  output  1  valid with done; err was seen during CHECK.
- done_bad  output  1  valid with done; request was rejected because addr==3.

Behaviour:
- Reset values: pkt_valid=0, data_out=0x00, done/done_err/done_bad=0, state IDLE, pointers and parity 0. Buffer contents are don't-care.
- Reset mid-packet aborts immediately: pkt_valid drops on the reset edge and no done pulse is issued.
- Header byte = {len[5:0], addr[1:0]}.
- Parity = XOR of header and all payload bytes, 8 bits. It is accumulated during LOAD and seeded with the header at request accept.
- Byte consumption: a byte on data_out is consumed at an edge where busy==0 and the state is HEADER, PAYLOAD or PARITY. While busy==1, data_out and pkt_valid hold unchanged.
- pkt_valid and data_out are registered. done, done_err and done_bad are registered.
- req_ready = (state==IDLE). pay_ready = (state==LOAD). Both are combinational from state.
- FSM transitions:
  - IDLE, request accepted:
    - addr==3: stay IDLE; next cycle done=1, done_bad=1, done_err=0.
    - len==0: go to HEADER.
    - otherwise: go to LOAD with wr_ptr=0.
  - LOAD: each pay handshake writes buf[wr_ptr], parity ^= pay_data, wr_ptr++. On the handshake with wr_ptr==len-1, go to HEADER and load data_out=header, pkt_valid=1 on that same edge. Header is therefore visible the cycle after the last payload handshake.
  - IDLE, len==0 case: header is loaded on the accept edge.
  - HEADER, consumed: if len>0, go to PAYLOAD with data_out=buf[0], rd_ptr=1. If len==0, go to PARITY with data_out=parity, pkt_valid=0.
  - PAYLOAD, consumed: if more bytes remain, data_out=buf[rd_ptr], rd_ptr++. After the last byte is consumed, go to PARITY with data_out=parity, pkt_valid=0.
  - PARITY, consumed: go to CHECK, cnt=ERR_WAIT, err_flag=0, data_out=0.
  - CHECK: each cycle err_flag |= err and cnt--. When cnt reaches 0, pulse done with done_err=err_flag, done_bad=0, then go to IDLE.
- No gaps between header and payload bytes other than busy stalls; this is why the full payload is buffered first.
- err outside CHECK is ignored.
- req_* inputs are ignored outside IDLE. pay_* inputs are ignored outside LOAD.
- The next request may be accepted in the cycle after the done pulse (state is IDLE during done).

Decomposition:
- Package router_pkg:
  - tx state enum: IDLE, LOAD, HEADER, PAYLOAD, PARITY, CHECK.
  - Constants: ADDR_W=2, LEN_W=6, NUM_PORTS=3, ADDR_ILLEGAL=2'd3.
  - Header-pack helper function.
- Sub-module router_tx_buf: 64x8 simple dual-port register array with synchronous write and combinational read by rd_ptr. Shared with future per-port buffering.

Test Plan:
- addr=1, len=3, payload 11,22,33, busy=0 -> data_out 0x0D,0x11,0x22,0x33 with pkt_valid=1 on consecutive cycles, then 0x0D with pkt_valid=0; done after 3 CHECK cycles, done_err=0.
- Same packet, busy held high 2 cycles while 0x22 is presented -> 0x22 and pkt_valid=1 held 3 cycles, sequence otherwise unchanged, parity still 0x0D.
- addr=2, len=0 -> header 0x02 (pkt_valid=1) then parity 0x02 (pkt_valid=0); pay_ready never asserted.
- addr=3, len=5 -> no pkt_valid, pay_ready stays 0; done=1, done_bad=1 one cycle after accept.
- addr=0, len=2, err pulsed for one cycle during CHECK -> done=1, done_err=1; a second back-to-back request is accepted the cycle after done.
- resetn low during PAYLOAD byte 2 of a len=10 packet -> next edge pkt_valid=0, data_out=0, req_ready=1, no done; a fresh packet after reset is correct.
